byte_demux_16: RTL
==================

# byte_demux_16

Byte-to-word frame assembler for the tx controller: the write-side counterpart of the rx controller's registered 16:1 byte mux. It accepts a stream of 8-bit bytes with start-of-frame marking and fills 16 byte slots in the same slot order the rx mux reads them out. Slot 16 is filled first and slot 1 last. It presents the completed 128-bit word with a valid/ready handshake and applies backpressure while the word is unconsumed.

## Interface
- DATA_W, 8, byte width; the block is verified only at 8.
- ERRCNT_W, 8, width of the saturating sync-error counter.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous assert, active-high; one clock, async active-high reset.
- din  in  DATA_W  input byte.
- din_valid  in  1  din is valid this cycle.
- sof  in  1  qualifies din as the first byte of a frame; sampled only on an accepted byte.
- din_ready  out  1  byte accepted when din_valid && din_ready.
- sel  out  4  index of the next byte in the frame, 0..15. The next byte is written to slot 16-sel, matching the rx mux select encoding.
- word_out  out  16*DATA_W  assembled word. Slot k occupies [8k-1:8k-8], so the first byte lands in [127:120].
- word_valid  out  1  word_out holds a complete frame.
- word_ready  in  1  downstream consumes the word when word_valid && word_ready.
- err_sync  out  1  one-cycle pulse on a framing error.
- err_cnt  out  ERRCNT_W  count of err_sync pulses; saturates at all-ones.

## Operation
- The state machine has three states: IDLE (wait for sof), FILL (collecting), and FULL (word held).
- "Accept" means din_valid && din_ready.
- din_ready is combinational: (state != FULL) || word_ready. This is the only combinational input-to-output path.
- IDLE transitions:
  - Accept with sof=1: write slot 16, set sel=1, go to FILL.
  - Accept with sof=0: drop the byte, pulse err_sync, stay in IDLE.
- FILL transitions:
  - Accept with sof=0: write slot 16-sel and increment sel. If sel was 15, set sel=0 and go to FULL.
  - Accept with sof=1: abandon the partial frame, pulse err_sync, write slot 16, set sel=1, stay in FILL.
  - No accept: hold all state.
- FULL transitions:
  - word_valid=1; word_out is stable while word_ready=0.
  - word_ready=1 with no accept: go to IDLE.
  - word_ready=1 with accept and sof=1: write slot 16, set sel=1, go to FILL. The word being handed off is the pre-edge value.
  - word_ready=1 with accept and sof=0: drop the byte, pulse err_sync, go to IDLE.
- Slots are not cleared between frames. word_out is meaningful only while word_valid=1.
- err_cnt increments once per err_sync pulse and holds at 2^ERRCNT_W-1.

## Timing
- Reset values: state IDLE, sel=0, word_out=0, word_valid=0, err_sync=0, err_cnt=0.
- din_ready follows the IDLE state, so it is 1 while rst is high. Inputs are ignored during reset.
- Assertion of rst mid-frame or in FULL takes effect immediately. The partial or held frame is discarded without an err_sync pulse.
- Latency: the 16th byte accepted at edge N gives word_valid=1 and the complete word_out after edge N.
- Minimum frame period is 16 cycles. Back-to-back frames are lossless when word_ready=1 during FULL: first byte of frame N+1 accepted in the same cycle frame N is consumed.
- word_valid falls on the edge after the consuming cycle.
- err_sync is registered and high for exactly one cycle per error event.
- sel reflects the registered count; it changes only on accepted bytes, reset, or completion.

## Test plan
- **Basic frame:** after reset, send bytes 0x01..0x10 with sof on 0x01, din_valid continuous, word_ready=1 -> word_valid high for 1 cycle, 16 cycles after the first accept. word_out[127:120]=0x01 and word_out[7:0]=0x10. err_cnt=0.
- **Backpressure:** as the basic frame but with word_ready=0 for 5 cycles after completion -> word_out stable and din_ready=0 for those cycles. A byte offered meanwhile is not accepted. After word_ready=1, the next sof byte is accepted in the same cycle.
- **Back-to-back:** two frames (0xA0..0xAF, 0xB0..0xBF) with continuous valid and word_ready=1 -> two words 16 cycles apart, no gap cycle, second word[127:120]=0xB0.
- **Mid-frame sof:** sof on 0x11, 5 bytes, then sof on 0x22 plus 15 bytes -> one err_sync pulse, err_cnt=1, completed word[127:120]=0x22.
- **Orphan bytes:** 3 bytes with sof=0 in IDLE -> 3 err_sync pulses, err_cnt=3, no word_valid. Saturation check with ERRCNT_W=2 and 5 errors -> err_cnt=3.
- **Reset mid-frame:** assert rst asynchronously after 7 bytes -> sel=0 and word_valid=0 immediately with no err_sync. A following full frame assembles correctly.

Source files
------------

// File: rtl/byte_demux_16.sv
// Byte-to-word frame assembler: collects 16 bytes into a 128-bit word, first byte in the top slot,
// and holds the completed word under a valid/ready handshake with backpressure on the byte side.
module byte_demux_16 #(
    parameter int DATA_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    input  logic                  sof,
    output logic                  din_ready,
    output logic [3:0]            sel,
    output logic [16*DATA_W-1:0]  word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  err_sync,
    output logic [ERRCNT_W-1:0]   err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             sel_q, sel_d;
    logic [16*DATA_W-1:0]   word_q, word_d;
    logic                   word_valid_q, word_valid_d;
    logic                   err_sync_q, err_sync_d;
    logic [ERRCNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic                   accept;
    logic                   wr_en;
    logic [3:0]             wr_sel;
    logic [15:0]            slot_we;

    assign din_ready = (state_q != FULL) || word_ready;
    assign accept    = din_valid && din_ready;

    // Byte lane gi holds slot gi+1, which the select value 15-gi addresses.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            assign slot_we[gi] = wr_en && (wr_sel == 4'(15 - gi));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wr_en      = 1'b0;
        wr_sel     = sel_q;
        err_sync_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sof) begin
                        wr_en   = 1'b1;
                        wr_sel  = 4'd0;
                        sel_d   = 4'd1;
                        state_d = FILL;
                    end else begin
                        err_sync_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (sof) begin
                        err_sync_d = 1'b1;
                        wr_sel     = 4'd0;
                        sel_d      = 4'd1;
                    end else begin
                        wr_sel = sel_q;
                        sel_d  = sel_q + 4'd1;
                        if (sel_q == 4'd15) begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (word_ready) begin
                    state_d = IDLE;
                    if (accept) begin
                        if (sof) begin
                            wr_en   = 1'b1;
                            wr_sel  = 4'd0;
                            sel_d   = 4'd1;
                            state_d = FILL;
                        end else begin
                            err_sync_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        word_d = word_q;
        for (int i = 0; i < 16; i++) begin
            if (slot_we[i]) begin
                word_d[i*DATA_W +: DATA_W] = din;
            end
        end
    end

    assign word_valid_d = (state_d == FULL);
    assign err_cnt_d    = (err_sync_d && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 4'd0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            err_sync_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            err_sync_q   <= err_sync_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign sel        = sel_q;
    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign err_sync   = err_sync_q;
    assign err_cnt    = err_cnt_q;

endmodule
